// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC register, one-cycle synchronous ROM request,
// small instruction FIFO toward decode, and flush-on-redirect from execute.
module if_fetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              ROM_AW    = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int              BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [XLEN-1:0]   redirect_pc_i,
  output logic              rom_en_o,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [31:0]       rom_data_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [31:0]       inst_o,
  output logic [XLEN-1:0]   inst_pc_o,
  output logic              misalign_o
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0]  pc_q;
  logic             inflight_q;
  logic [XLEN-1:0]  inflight_pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic             misalign_q;
  logic [31:0]      inst_mem [BUF_DEPTH];
  logic [XLEN-1:0]  pc_mem   [BUF_DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CNT_W:0]   occupancy;

  // Occupancy counts the in-flight word so the FIFO can never overflow.
  assign occupancy    = {1'b0, cnt_q} + (CNT_W + 1)'(inflight_q);
  assign inst_valid_o = rst_n & (cnt_q != '0) & !redirect_i;
  assign pop          = inst_valid_o & inst_ready_i;
  assign push         = inflight_q & !redirect_i;
  assign issue        = rst_n & !redirect_i &
                        ((occupancy < (CNT_W + 1)'(BUF_DEPTH)) | pop);

  assign rom_en_o   = issue;
  assign rom_addr_o = pc_q[ROM_AW+1:2];
  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
  assign inst_o     = (cnt_q == '0) ? NOP : inst_mem[rd_ptr_q];
  assign inst_pc_o  = (cnt_q == '0) ? '0  : pc_mem[rd_ptr_q];

  // Request stage: PC, in-flight tracking and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q       <= {redirect_pc_i[XLEN-1:2], 2'b00};
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= (redirect_pc_i[1:0] != 2'b00);
    end else begin
      misalign_q <= 1'b0;
      inflight_q <= issue;
      if (issue) pc_q <= pc_q + XLEN'(4);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Return stage: capture the ROM word alongside the PC that requested it.
  always_ff @(posedge clk) begin
    if (issue) inflight_pc_q <= pc_q;
    if (push) begin
      inst_mem[wr_ptr_q] <= rom_data_i;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule
